// File: rtl/top_k_tracker.sv
// top_k_tracker: streaming rank tracker holding the K largest samples seen
// since the last clear. The table is a descending sorted register array, and
// occupied slots are always contiguous from rank 0. It reports the K-th
// largest sample every cycle, a random-access rank readout and a per-frame
// result.
module top_k_tracker #(
  parameter int W          = 32,
  parameter int K          = 2,
  parameter bit SIGNED     = 1'b0,
  parameter bit AUTO_CLEAR = 1'b1,
  localparam int IW        = (K > 1) ? $clog2(K) : 1,
  localparam int CW        = $clog2(K + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          in_valid_i,
  input  logic [W-1:0]  in_data_i,
  input  logic          in_last_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o,
  output logic          rd_valid_o,
  output logic [W-1:0]  kth_data_o,
  output logic          kth_valid_o,
  output logic [CW-1:0] count_o,
  output logic          frame_done_o,
  output logic [W-1:0]  frame_kth_o,
  output logic          frame_kth_valid_o
);

  localparam logic [CW-1:0] K_CNT = CW'(K);

  logic [W-1:0]  data_q [K];
  logic [K-1:0]  occ_q;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  ins_data [K];
  logic [K-1:0]  ins_occ;
  logic [W-1:0]  nxt_data [K];
  logic [K-1:0]  nxt_occ;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          frame_done_q;
  logic [W-1:0]  frame_kth_q;
  logic          frame_kth_valid_q;
  logic          accept, frame_end;

  // Strict greater-than in the configured number format.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // A clear in the same cycle drops the sample, including its frame end.
  assign accept    = in_valid_i && !clear_i;
  assign frame_end = accept && in_last_i;

  // Build the table as it would look with in_data inserted. Because the table
  // is sorted, the "take" flag is monotonic: the first slot that takes the
  // sample stores it, and every later taking slot takes its upper neighbour.
  always_comb begin
    logic [W-1:0] prev_data;
    logic         prev_occ;
    logic         prev_take;
    logic         take;
    prev_data = '0;
    prev_occ  = 1'b0;
    prev_take = 1'b0;
    take      = 1'b0;
    for (int i = 0; i < K; i++) begin
      take        = !occ_q[i] || gt(in_data_i, data_q[i]);
      ins_data[i] = data_q[i];
      ins_occ[i]  = occ_q[i];
      if (take) begin
        if (prev_take) begin
          ins_data[i] = prev_data;
          ins_occ[i]  = prev_occ;
        end else begin
          ins_data[i] = in_data_i;
          ins_occ[i]  = 1'b1;
        end
      end
      prev_data = data_q[i];
      prev_occ  = occ_q[i];
      prev_take = take;
    end
  end

  // Next table state: flush, insert or hold.
  always_comb begin
    nxt_data = data_q;
    nxt_occ  = occ_q;
    count_d  = count_q;
    if (clear_i || (frame_end && AUTO_CLEAR)) begin
      for (int i = 0; i < K; i++) nxt_data[i] = '0;
      nxt_occ = '0;
      count_d = '0;
    end else if (accept) begin
      nxt_data = ins_data;
      nxt_occ  = ins_occ;
      if (count_q < K_CNT) count_d = count_q + 1'b1;
    end
  end

  // Rank readout taken from the post-edge table; ranks beyond K read as empty.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    if (int'(rd_idx_i) < K) begin
      rd_data_d  = nxt_data[rd_idx_i];
      rd_valid_d = nxt_occ[rd_idx_i];
    end
  end

  // Table, readout and frame-result registers. The frame result captures the
  // post-insertion last rank, even when auto-clear empties the table.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < K; i++) data_q[i] <= '0;
      occ_q             <= '0;
      count_q           <= '0;
      rd_data_q         <= '0;
      rd_valid_q        <= 1'b0;
      frame_done_q      <= 1'b0;
      frame_kth_q       <= '0;
      frame_kth_valid_q <= 1'b0;
    end else begin
      data_q       <= nxt_data;
      occ_q        <= nxt_occ;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_end;
      if (frame_end) begin
        frame_kth_q       <= ins_data[K-1];
        frame_kth_valid_q <= ins_occ[K-1];
      end
    end
  end

  assign rd_data_o         = rd_data_q;
  assign rd_valid_o        = rd_valid_q;
  assign kth_data_o        = data_q[K-1];
  assign kth_valid_o       = occ_q[K-1];
  assign count_o           = count_q;
  assign frame_done_o      = frame_done_q;
  assign frame_kth_o       = frame_kth_q;
  assign frame_kth_valid_o = frame_kth_valid_q;

endmodule

// File: tb/tb_top_k_tracker.sv
// Bench for top_k_tracker: two instances (K=2/W=32 unsigned with auto-clear,
// K=4/W=8 signed accumulating). Stimulus pushes expected values tagged with
// the cycle at which they must be visible; a monitor pops and compares them
// on the falling edge. Frame results go through a separate queue popped on
// each frame_done pulse.
module tb_top_k_tracker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: K=2, W=32, unsigned, auto-clear
  logic        a_clear = 0, a_in_valid = 0, a_in_last = 0;
  logic [31:0] a_in_data = '0;
  logic [0:0]  a_rd_idx = '0;
  logic [31:0] a_rd_data, a_kth_data, a_frame_kth;
  logic        a_rd_valid, a_kth_valid, a_frame_done, a_frame_kth_valid;
  logic [1:0]  a_count;

  // Instance B: K=4, W=8, signed, accumulate across frames
  logic        b_clear = 0, b_in_valid = 0, b_in_last = 0;
  logic [7:0]  b_in_data = '0;
  logic [1:0]  b_rd_idx = '0;
  logic [7:0]  b_rd_data, b_kth_data, b_frame_kth;
  logic        b_rd_valid, b_kth_valid, b_frame_done, b_frame_kth_valid;
  logic [2:0]  b_count;

  top_k_tracker #(.W(32), .K(2), .SIGNED(1'b0), .AUTO_CLEAR(1'b1)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .clear_i(a_clear), .in_valid_i(a_in_valid),
    .in_data_i(a_in_data), .in_last_i(a_in_last), .rd_idx_i(a_rd_idx),
    .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .kth_data_o(a_kth_data),
    .kth_valid_o(a_kth_valid), .count_o(a_count), .frame_done_o(a_frame_done),
    .frame_kth_o(a_frame_kth), .frame_kth_valid_o(a_frame_kth_valid));

  top_k_tracker #(.W(8), .K(4), .SIGNED(1'b1), .AUTO_CLEAR(1'b0)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .clear_i(b_clear), .in_valid_i(b_in_valid),
    .in_data_i(b_in_data), .in_last_i(b_in_last), .rd_idx_i(b_rd_idx),
    .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .kth_data_o(b_kth_data),
    .kth_valid_o(b_kth_valid), .count_o(b_count), .frame_done_o(b_frame_done),
    .frame_kth_o(b_frame_kth), .frame_kth_valid_o(b_frame_kth_valid));

  localparam int S_A_KTH = 0, S_A_KV = 1, S_A_CNT = 2, S_A_RD = 3, S_A_RV = 4;
  localparam int S_A_FD = 5, S_A_FK = 6, S_A_FV = 7;
  localparam int S_B_KTH = 10, S_B_KV = 11, S_B_CNT = 12, S_B_RD = 13, S_B_RV = 14;
  localparam int S_B_FD = 15, S_B_FK = 16, S_B_FV = 17;

  typedef struct {
    int          tag;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] kth;
    logic        v;
  } fexp_t;

  exp_t  sq[$];
  fexp_t fq_a[$];
  fexp_t fq_b[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_A_KTH: obs = a_kth_data;
      S_A_KV:  obs = 32'(a_kth_valid);
      S_A_CNT: obs = 32'(a_count);
      S_A_RD:  obs = a_rd_data;
      S_A_RV:  obs = 32'(a_rd_valid);
      S_A_FD:  obs = 32'(a_frame_done);
      S_A_FK:  obs = a_frame_kth;
      S_A_FV:  obs = 32'(a_frame_kth_valid);
      S_B_KTH: obs = 32'(b_kth_data);
      S_B_KV:  obs = 32'(b_kth_valid);
      S_B_CNT: obs = 32'(b_count);
      S_B_RD:  obs = 32'(b_rd_data);
      S_B_RV:  obs = 32'(b_rd_valid);
      S_B_FD:  obs = 32'(b_frame_done);
      S_B_FK:  obs = 32'(b_frame_kth);
      S_B_FV:  obs = 32'(b_frame_kth_valid);
      default: obs = '0;
    endcase
  endfunction

  task automatic exp_n(input int sel, input logic [31:0] v, input string nm);
    sq.push_back('{tag: cyc + 1, sel: sel, val: v, name: nm});
  endtask

  task automatic exp_0(input int sel, input logic [31:0] v, input string nm);
    sq.push_back('{tag: cyc, sel: sel, val: v, name: nm});
  endtask

  task automatic step_a(input logic v, input logic [31:0] d, input logic l,
                        input logic c, input logic idx);
    @(posedge clk);
    #1;
    a_in_valid = v; a_in_data = d; a_in_last = l; a_clear = c; a_rd_idx = idx;
    b_in_valid = 0; b_in_last = 0; b_clear = 0;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic l,
                        input logic c, input logic [1:0] idx);
    @(posedge clk);
    #1;
    b_in_valid = v; b_in_data = d; b_in_last = l; b_clear = c; b_rd_idx = idx;
    a_in_valid = 0; a_in_last = 0; a_clear = 0;
  endtask

  // Monitor: per-cycle expectations plus frame results on each frame_done.
  always @(negedge clk) begin
    while (sq.size() != 0 && sq[0].tag <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = sq.pop_front();
      got = obs(e.sel);
      n_cmp++;
      if (got !== e.val) begin
        n_err++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h", e.name, cyc, got, e.val);
      end
    end
    if (a_frame_done === 1'b1) begin
      n_cmp++;
      if (fq_a.size() == 0) begin
        n_err++;
        $display("FAIL a_frame_unexpected (cycle %0d): got frame_done=1 expected 0", cyc);
      end else begin
        fexp_t f;
        f = fq_a.pop_front();
        if (a_frame_kth !== f.kth || a_frame_kth_valid !== f.v) begin
          n_err++;
          $display("FAIL a_frame_result (cycle %0d): got kth=%0h v=%0b expected kth=%0h v=%0b",
                   cyc, a_frame_kth, a_frame_kth_valid, f.kth, f.v);
        end
      end
    end
    if (b_frame_done === 1'b1) begin
      n_cmp++;
      if (fq_b.size() == 0) begin
        n_err++;
        $display("FAIL b_frame_unexpected (cycle %0d): got frame_done=1 expected 0", cyc);
      end else begin
        fexp_t f;
        f = fq_b.pop_front();
        if (32'(b_frame_kth) !== f.kth || b_frame_kth_valid !== f.v) begin
          n_err++;
          $display("FAIL b_frame_result (cycle %0d): got kth=%0h v=%0b expected kth=%0h v=%0b",
                   cyc, b_frame_kth, b_frame_kth_valid, f.kth, f.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    exp_0(S_A_KTH, 0, "rst_a_kth");   exp_0(S_A_KV, 0, "rst_a_kv");
    exp_0(S_A_CNT, 0, "rst_a_cnt");   exp_0(S_A_RD, 0, "rst_a_rd");
    exp_0(S_A_RV, 0, "rst_a_rv");     exp_0(S_A_FD, 0, "rst_a_fd");
    exp_0(S_A_FK, 0, "rst_a_fk");     exp_0(S_A_FV, 0, "rst_a_fv");
    exp_0(S_B_CNT, 0, "rst_b_cnt");   exp_0(S_B_KV, 0, "rst_b_kv");

    // Basic second-largest: 5, 9, 3, 9, 12
    step_a(1, 5, 0, 0, 0);
    exp_n(S_A_KTH, 0, "b5_kth"); exp_n(S_A_KV, 0, "b5_kv"); exp_n(S_A_CNT, 1, "b5_cnt");
    exp_n(S_A_RD, 5, "b5_rd");   exp_n(S_A_RV, 1, "b5_rv");
    step_a(1, 9, 0, 0, 0);
    exp_n(S_A_KTH, 5, "b9_kth"); exp_n(S_A_KV, 1, "b9_kv"); exp_n(S_A_CNT, 2, "b9_cnt");
    step_a(1, 3, 0, 0, 0);
    exp_n(S_A_KTH, 5, "b3_kth"); exp_n(S_A_KV, 1, "b3_kv"); exp_n(S_A_RD, 9, "b3_rd");
    step_a(1, 9, 0, 0, 0);
    exp_n(S_A_KTH, 9, "b9b_kth"); exp_n(S_A_KV, 1, "b9b_kv");
    step_a(1, 12, 0, 0, 0);
    exp_n(S_A_KTH, 9, "b12_kth"); exp_n(S_A_RD, 12, "b12_rd0"); exp_n(S_A_CNT, 2, "b12_cnt");
    exp_n(S_A_FD, 0, "b12_fd");
    step_a(0, 0, 0, 0, 1);
    exp_n(S_A_RD, 9, "b_rd1"); exp_n(S_A_RV, 1, "b_rv1");

    // Synchronous clear
    step_a(0, 0, 0, 1, 1);
    exp_n(S_A_CNT, 0, "clr_cnt"); exp_n(S_A_KV, 0, "clr_kv"); exp_n(S_A_KTH, 0, "clr_kth");
    exp_n(S_A_RV, 0, "clr_rv");   exp_n(S_A_RD, 0, "clr_rd");

    // Frames with auto-clear, back to back
    step_a(1, 4, 0, 0, 0);
    exp_n(S_A_CNT, 1, "f1a_cnt");
    step_a(1, 8, 0, 0, 0);
    exp_n(S_A_KTH, 4, "f1b_kth"); exp_n(S_A_CNT, 2, "f1b_cnt");
    step_a(1, 6, 1, 0, 0);
    fq_a.push_back('{kth: 6, v: 1'b1});
    exp_n(S_A_FD, 1, "f1_fd"); exp_n(S_A_CNT, 0, "f1_cnt"); exp_n(S_A_KV, 0, "f1_kv");
    step_a(1, 2, 1, 0, 0);
    fq_a.push_back('{kth: 0, v: 1'b0});
    exp_n(S_A_FD, 1, "f2_fd"); exp_n(S_A_CNT, 0, "f2_cnt");
    step_a(1, 3, 0, 0, 0);
    exp_n(S_A_FD, 0, "f3a_fd"); exp_n(S_A_CNT, 1, "f3a_cnt"); exp_n(S_A_FV, 0, "f3a_fv_hold");
    step_a(1, 1, 1, 0, 0);
    fq_a.push_back('{kth: 1, v: 1'b1});
    exp_n(S_A_FD, 1, "f3_fd");
    step_a(0, 0, 0, 0, 0);
    exp_n(S_A_FD, 0, "f3_fd_end"); exp_n(S_A_FK, 1, "f3_fk_hold"); exp_n(S_A_FV, 1, "f3_fv_hold");

    // clear colliding with a frame-end sample
    step_a(1, 20, 0, 0, 0);
    exp_n(S_A_CNT, 1, "col_pre_cnt"); exp_n(S_A_RD, 20, "col_pre_rd");
    step_a(1, 50, 1, 1, 0);
    exp_n(S_A_CNT, 0, "col_cnt"); exp_n(S_A_FD, 0, "col_fd"); exp_n(S_A_FK, 1, "col_fk");
    exp_n(S_A_RV, 0, "col_rv");
    step_a(0, 0, 1, 0, 0);
    exp_n(S_A_FD, 0, "lastnov_fd");

    // Ties and depth on K=4
    step_b(1, 8'd7, 0, 0, 2'd0);
    exp_n(S_B_CNT, 1, "t1_cnt"); exp_n(S_B_RD, 7, "t1_rd0");
    step_b(1, 8'd7, 0, 0, 2'd1);
    exp_n(S_B_CNT, 2, "t2_cnt"); exp_n(S_B_RD, 7, "t2_rd1");
    step_b(1, 8'd7, 0, 0, 2'd2);
    exp_n(S_B_CNT, 3, "t3_cnt"); exp_n(S_B_RD, 7, "t3_rd2"); exp_n(S_B_KV, 0, "t3_kv");
    step_b(1, 8'd1, 0, 0, 2'd3);
    exp_n(S_B_CNT, 4, "t4_cnt"); exp_n(S_B_RD, 1, "t4_rd3"); exp_n(S_B_KTH, 1, "t4_kth");
    exp_n(S_B_KV, 1, "t4_kv");
    step_b(1, 8'd0, 0, 0, 2'd0);
    exp_n(S_B_CNT, 4, "t0_cnt"); exp_n(S_B_KTH, 1, "t0_kth"); exp_n(S_B_RD, 7, "t0_rd0");
    step_b(1, 8'd5, 0, 0, 2'd2);
    exp_n(S_B_KTH, 5, "t5_kth"); exp_n(S_B_RD, 7, "t5_rd2");
    step_b(1, 8'd8, 0, 0, 2'd0);
    exp_n(S_B_KTH, 7, "t8_kth"); exp_n(S_B_RD, 8, "t8_rd0");

    // Frame end without auto-clear keeps the table
    step_b(1, 8'd9, 1, 0, 2'd0);
    fq_b.push_back('{kth: 7, v: 1'b1});
    exp_n(S_B_FD, 1, "bf_fd"); exp_n(S_B_CNT, 4, "bf_cnt"); exp_n(S_B_RD, 9, "bf_rd0");
    step_b(0, 8'd0, 0, 1, 2'd0);
    exp_n(S_B_CNT, 0, "bclr_cnt"); exp_n(S_B_KV, 0, "bclr_kv"); exp_n(S_B_FK, 7, "bclr_fk");
    exp_n(S_B_FD, 0, "bclr_fd");

    // Signed ordering
    step_b(1, 8'hFF, 0, 0, 2'd0);
    exp_n(S_B_RD, 8'hFF, "s1_rd0");
    step_b(1, 8'h80, 0, 0, 2'd1);
    exp_n(S_B_RD, 8'h80, "s2_rd1");
    step_b(1, 8'h01, 0, 0, 2'd0);
    exp_n(S_B_RD, 8'h01, "s3_rd0");
    step_b(1, 8'h7F, 0, 0, 2'd3);
    exp_n(S_B_KTH, 8'h80, "s4_kth"); exp_n(S_B_RD, 8'h80, "s4_rd3"); exp_n(S_B_CNT, 4, "s4_cnt");
    step_b(1, 8'h81, 0, 0, 2'd2);
    exp_n(S_B_KTH, 8'h81, "s5_kth"); exp_n(S_B_RD, 8'hFF, "s5_rd2");

    // Asynchronous reset mid-stream, between edges
    step_a(1, 7, 0, 0, 0);
    step_a(1, 9, 0, 0, 0);
    exp_n(S_A_CNT, 2, "pre_rst_cnt"); exp_n(S_A_KTH, 7, "pre_rst_kth");
    step_a(0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    #2 reset = 1;
    exp_0(S_A_KTH, 0, "ar_a_kth"); exp_0(S_A_KV, 0, "ar_a_kv");   exp_0(S_A_CNT, 0, "ar_a_cnt");
    exp_0(S_A_RD, 0, "ar_a_rd");   exp_0(S_A_RV, 0, "ar_a_rv");   exp_0(S_A_FD, 0, "ar_a_fd");
    exp_0(S_A_FK, 0, "ar_a_fk");   exp_0(S_A_FV, 0, "ar_a_fv");
    exp_0(S_B_CNT, 0, "ar_b_cnt"); exp_0(S_B_KTH, 0, "ar_b_kth"); exp_0(S_B_FK, 0, "ar_b_fk");
    exp_0(S_B_FV, 0, "ar_b_fv");   exp_0(S_B_RD, 0, "ar_b_rd");
    @(posedge clk);
    #1 reset = 0;

    // Resume after reset
    step_a(1, 3, 0, 0, 0);
    exp_n(S_A_KTH, 0, "rs1_kth"); exp_n(S_A_KV, 0, "rs1_kv"); exp_n(S_A_CNT, 1, "rs1_cnt");
    exp_n(S_A_RD, 3, "rs1_rd");
    step_a(1, 4, 0, 0, 0);
    exp_n(S_A_KTH, 3, "rs2_kth"); exp_n(S_A_KV, 1, "rs2_kv"); exp_n(S_A_RD, 4, "rs2_rd");
    step_a(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    n_cmp++;
    if (sq.size() != 0) begin
      n_err++;
      $display("FAIL pending_expect: got %0d left expected 0", sq.size());
    end
    n_cmp++;
    if (fq_a.size() != 0 || fq_b.size() != 0) begin
      n_err++;
      $display("FAIL missing_frame_done: got %0d/%0d left expected 0/0", fq_a.size(), fq_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
